// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a two-entry skid buffer, registered in_ready and synchronous flush.
// Optional counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
    parameter int DATA_W              = 64,
    parameter int CTRL_W              = 12,
    parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic                main_valid_s, skid_valid_s, in_fire_s, out_fire_s;
    logic [1:0]          occupancy_s;

    assign main_valid_s = (state_q == ST_FULL) || (state_q == ST_SKID);
    assign skid_valid_s = (state_q == ST_SKID);
    assign in_fire_s    = in_valid & in_ready_q;
    assign out_fire_s   = main_valid_s & out_ready;

    // State and storage registers; reset clears everything, including in_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Next-state and datapath selection; flush overrides the handshake result.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                    state_d     = ST_FULL;
                end else begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (in_fire_s && out_fire_s) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (in_fire_s) begin
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                    state_d     = ST_SKID;
                end else if (out_fire_s) begin
                    state_d     = ST_EMPTY;
                end else begin
                    state_d     = ST_FULL;
                end
            end
            ST_SKID: begin
                if (out_fire_s) begin
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    state_d     = ST_FULL;
                end else begin
                    state_d     = ST_SKID;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA_ON_FLUSH == 1'b1) begin
                main_data_d = '0;
                skid_data_d = '0;
            end else begin
                main_data_d = main_data_q;
                skid_data_d = skid_data_q;
            end
        end else begin
            state_d = state_d;
        end
        // Ready depends only on the next state, so there is no path from out_ready.
        in_ready_d = (state_d != ST_SKID);
    end

    // Occupancy decode from the current state.
    always_comb begin
        occupancy_s = 2'd0;
        case (state_q)
            ST_EMPTY: occupancy_s = 2'd0;
            ST_FULL:  occupancy_s = 2'd1;
            ST_SKID:  occupancy_s = 2'd2;
            default:  occupancy_s = 2'd0;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_s;
    assign out_ctrl  = main_valid_s ? main_ctrl_q : {CTRL_W{1'b0}};
    assign out_data  = main_data_q;
    assign occupancy = occupancy_s;

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_q, flush_cnt_q;

    // Saturating stall and flush counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q     <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (main_valid_s && !out_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'h0001;
            end else begin
                stall_q <= stall_q;
            end
            if (flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'h0001;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_cnt_q;
`endif

    // skid_valid_s is kept for readability of the state decode.
    logic unused_s;
    assign unused_s = skid_valid_s;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a queue holds beats accepted upstream and is
// popped as they leave, giving expected out_*, occupancy and in_ready every cycle.
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]       stall_cycles;
    logic [15:0]       flush_count;
    int                exp_stall = 0;
    int                exp_flush = 0;
`endif

    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;

    pipe_stage_skid #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA_ON_FLUSH(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [CTRL_W-1:0] mkctrl(input logic [DATA_W-1:0] d);
        return {d[CTRL_W-2:0], 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = mkctrl(d);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic check_state();
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("out_ctrl", 64'(out_ctrl), (sb.size() != 0) ? 64'(sb[0].c) : 64'd0);
        if (sb.size() != 0) chk("out_data", out_data, sb[0].d);
    endtask

    // One clock: check pre-edge handshake, advance, update scoreboard, check post-edge state.
    task automatic cycle();
        logic inf, outf;
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        inf  = in_valid & in_ready;
        outf = out_valid & out_ready;
        if (outf) begin
            if (sb.size() != 0) chk("out_fire_data", out_data, sb[0].d);
            else chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end
`ifdef PIPE_STAGE_STATS_EN
        if (out_valid && !out_ready && exp_stall < 65535) exp_stall++;
        if (flush && exp_flush < 65535) exp_flush++;
`endif
        @(posedge clk);
        #1;
        if (outf && sb.size() != 0) void'(sb.pop_front());
        if (flush) sb.delete();
        else if (inf) sb.push_back('{c: mkctrl(in_data), d: in_data});
        check_state();
    endtask

    initial begin
        // Reset held low with a beat offered upstream.
        reset = 1'b0;
        drive(1'b1, 64'hDEAD, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_post_edge", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("rst_flush_count", 64'(flush_count), 64'd0);
`endif

        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        cycle();

        // Back-pressure: A held, B goes to skid, extra beat refused, then drain in order.
        drive(1'b1, 64'h11, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h22, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h99, 1'b0, 1'b0); cycle();
        drive(1'b0, 64'd0, 1'b1, 1'b0);  cycle(); cycle(); cycle();

        // Unknown inputs while in_valid is low must not reach out_ctrl.
        drive(1'b1, 64'h44, 1'b0, 1'b0); cycle();
        in_valid = 1'b0;
        in_ctrl  = 'x;
        in_data  = 'x;
        cycle(); cycle();

        // Flush in FULL: 0x44 leaves in the flush cycle, 0x55 accepted then discarded.
        drive(1'b1, 64'h55, 1'b1, 1'b1); cycle();
        chk("flush_full_data_zero", out_data, 64'd0);

        // Flush in SKID with C=0x33 offered.
        drive(1'b1, 64'h66, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h77, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h33, 1'b0, 1'b1); cycle();
        chk("flush_skid_data_zero", out_data, 64'd0);
        chk("flush_skid_in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 64'd0, 1'b1, 1'b0); cycle(); cycle();

        // Asynchronous reset between edges while in SKID.
        drive(1'b1, 64'h88, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h99, 1'b0, 1'b0); cycle();
        chk("pre_async_occupancy", 64'(occupancy), 64'd2);
        #3;
        reset = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("async_out_data", out_data, 64'd0);
        chk("async_occupancy", 64'(occupancy), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
`ifdef PIPE_STAGE_STATS_EN
        exp_stall = 0;
        exp_flush = 0;
`endif
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("async_rel_in_ready", 64'(in_ready), 64'd1);
        check_state();

`ifdef PIPE_STAGE_STATS_EN
        // Five stalls, then two flushes.
        drive(1'b1, 64'hAB, 1'b0, 1'b0); cycle();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        repeat (5) cycle();
        drive(1'b0, 64'd0, 1'b1, 1'b1);
        cycle(); cycle();
        chk("stall_cycles_5", 64'(stall_cycles), 64'd5);
        chk("flush_count_2", 64'(flush_count), 64'd2);
        chk("stall_model", 64'(stall_cycles), 64'(exp_stall));
        chk("flush_model", 64'(flush_count), 64'(exp_flush));
        // Saturation.
        drive(1'b1, 64'hCD, 1'b0, 1'b0); cycle();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_saturate", 64'(stall_cycles), 64'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register and successor to the fixed-field inter-stage registers. It carries a control field and a data field between pipeline stages using a valid/ready handshake. A two-entry skid buffer lets a downstream stall back-pressure upstream without a combinational ready path, and a synchronous flush inserts a bubble. One instance replaces each hand-written IF/ID, ID/EX, EX/MEM or MEM/WB register.

Parameters:
DATA_W, 64, width of the data field (operands, immediates, register addresses, packed).
CTRL_W, 12, width of the control field (regWrite, memRead, aluOp, ...). Forced to zero in every bubble.
CLEAR_DATA_ON_FLUSH, 1, 1 = data field zeroed on flush/reset; 0 = data field holds its previous value (area saving).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
flush  input  1  synchronous bubble insert (hazard/branch squash)
in_valid  input  1  upstream presents a beat
in_ready  output  1  stage can accept a beat; registered
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream data field
out_valid  output  1  main register holds a beat
out_ready  input  1  downstream accepts the beat
out_ctrl  output  CTRL_W  control field; 0 whenever out_valid=0
out_data  output  DATA_W  data field
occupancy  output  2  number of held beats (0, 1 or 2)

Behaviour:
- Storage: main register (drives out_*) plus skid register. Each has its own valid bit.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occ 0), FULL (main valid, occ 1), SKID (both valid, occ 2).
- in_ready = 1 in EMPTY/FULL, 0 in SKID. It is a flop output with no combinational path from out_ready.
- EMPTY: in_fire -> load main, go to FULL. out_valid becomes 1 the next cycle (latency 1).
- FULL:
  - in_fire & out_fire -> main <= input, stay FULL.
  - in_fire & !out_fire -> skid <= input, go to SKID.
  - !in_fire & out_fire -> go to EMPTY.
- SKID (in_fire impossible): out_fire -> main <= skid, go to FULL; else hold.
- Beats leave in arrival order. No beat is dropped or duplicated unless flushed.
- Flush (sync, highest priority after reset): next cycle is EMPTY, out_ctrl = 0, in_ready = 1. A beat accepted in the flush cycle is discarded. out_fire in the flush cycle still completes downstream. Data field is zeroed only if CLEAR_DATA_ON_FLUSH=1.
- Reset asserted (any time, including mid-SKID): immediately EMPTY, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0 while reset is low. in_ready rises on the first clk edge after reset deasserts.
- out_ctrl is explicitly gated to 0 when main is invalid, so control never leaks from a stale register.
- Unknown in_* while in_valid=0 must not propagate to out_ctrl.

Optional Feature:
PIPE_STAGE_STATS_EN:
- Defined: adds outputs stall_cycles[15:0] and flush_count[15:0], both saturating at 16'hFFFF and cleared by reset.
  - stall_cycles increments each cycle with out_valid & !out_ready.
  - flush_count increments each cycle flush=1.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=0. Release reset -> in_ready=1 after 1 edge.
- Streaming: out_ready=1, beats data 1..8 on consecutive cycles -> identical sequence at out_data, 1-cycle latency, in_ready stays 1, occupancy=1.
- Back-pressure: out_ready=0 after beat A=0x11 is held -> B=0x22 accepted into skid, occupancy=2, in_ready=0 next cycle. Release out_ready -> A, then B, no loss.
- Flush in SKID: occupancy=2, flush=1 with in_valid=1 (C=0x33) -> next cycle out_valid=0, out_ctrl=0, occupancy=0. C never appears at output.
- Async reset mid-SKID: pull reset low between clock edges -> outputs zero immediately, without waiting for clk.
- Stats (macro defined): 5 stall cycles and 2 flushes -> stall_cycles=5, flush_count=2. Forcing 70000 stalls -> stall_cycles=16'hFFFF.
